// File: rtl/load_store_unit.sv
// Memory stage: turns the ALU result into a byte/halfword/word bus access and
// delivers one registered writeback result (or exception) per instruction.
module load_store_unit #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [3:0]  ex_mem_op,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic [2:0]  wb_exc,
    output logic [31:0] wb_exc_addr
);

    localparam logic [3:0] OpLb  = 4'd1;
    localparam logic [3:0] OpLh  = 4'd2;
    localparam logic [3:0] OpLw  = 4'd3;
    localparam logic [3:0] OpLbu = 4'd4;
    localparam logic [3:0] OpLhu = 4'd5;
    localparam logic [3:0] OpSb  = 4'd6;
    localparam logic [3:0] OpSh  = 4'd7;
    localparam logic [3:0] OpSw  = 4'd8;

    typedef enum logic [0:0] {StIdle, StBus} state_t;

    state_t      r_state;
    state_t      w_state_d;
    logic [3:0]  r_op;
    logic [31:0] r_addr;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic [31:0] r_cnt;

    logic        w_accept;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_start;
    logic        w_done_ack;
    logic        w_done_to;
    logic        w_timeout;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

    assign ex_ready = (r_state == StIdle);
    assign w_accept = ex_valid && ex_ready;
    assign w_timeout = (BUS_TIMEOUT != 32'd0) && ((r_cnt + 32'd1) == BUS_TIMEOUT);

    // Decode and store formatting for the instruction currently offered by execute.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_half  = 1'b0;
        w_is_word  = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = 32'd0;
        case (ex_mem_op)
            OpLb, OpLbu: w_is_load = 1'b1;
            OpLh, OpLhu: begin
                w_is_load = 1'b1;
                w_is_half = 1'b1;
            end
            OpLw: begin
                w_is_load = 1'b1;
                w_is_word = 1'b1;
            end
            OpSb: begin
                w_is_store = 1'b1;
                w_be       = 4'b0001 << ex_result[1:0];
                w_wdata    = {4{ex_store_data[7:0]}};
            end
            OpSh: begin
                w_is_store = 1'b1;
                w_is_half  = 1'b1;
                w_be       = ex_result[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{ex_store_data[15:0]}};
            end
            OpSw: begin
                w_is_store = 1'b1;
                w_is_word  = 1'b1;
                w_wdata    = ex_store_data;
            end
            default: ;
        endcase
        w_misaligned = (w_is_half && ex_result[0]) || (w_is_word && (ex_result[1:0] != 2'b00));
    end

    always_comb begin
        w_shifted   = bus_rdata >> {r_addr[1:0], 3'b000};
        w_load_data = w_shifted;
        case (r_op)
            OpLb:    w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            OpLbu:   w_load_data = {24'd0, w_shifted[7:0]};
            OpLh:    w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            OpLhu:   w_load_data = {16'd0, w_shifted[15:0]};
            OpLw:    w_load_data = bus_rdata;
            default: w_load_data = 32'd0;
        endcase
    end

    always_comb begin
        w_state_d  = r_state;
        w_start    = 1'b0;
        w_done_ack = 1'b0;
        w_done_to  = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_accept && (w_is_load || w_is_store) && !w_misaligned) begin
                    w_start   = 1'b1;
                    w_state_d = StBus;
                end
            end
            StBus: begin
                // An ack on the limit cycle wins over the timeout.
                if (bus_ack) begin
                    w_done_ack = 1'b1;
                    w_state_d  = StIdle;
                end else if (w_timeout) begin
                    w_done_to = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_op         <= 4'd0;
            r_addr       <= 32'd0;
            r_rd         <= 5'd0;
            r_reg_write  <= 1'b0;
            r_cnt        <= 32'd0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'd0;
            bus_be       <= 4'd0;
            bus_wdata    <= 32'd0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'd0;
            wb_exc       <= 3'd0;
            wb_exc_addr  <= 32'd0;
        end else begin
            r_state  <= w_state_d;
            wb_valid <= 1'b0;
            if (w_start) begin
                r_op        <= ex_mem_op;
                r_addr      <= ex_result;
                r_rd        <= ex_rd;
                r_reg_write <= ex_reg_write;
                r_cnt       <= 32'd0;
                bus_req     <= 1'b1;
                bus_we      <= w_is_store;
                bus_addr    <= {ex_result[31:2], 2'b00};
                bus_be      <= w_be;
                bus_wdata   <= w_wdata;
            end else if (r_state == StIdle && w_accept) begin
                wb_valid <= 1'b1;
                wb_rd    <= ex_rd;
                if (w_misaligned) begin
                    wb_reg_write <= 1'b0;
                    wb_data      <= 32'd0;
                    wb_exc       <= w_is_store ? 3'd2 : 3'd1;
                    wb_exc_addr  <= ex_result;
                end else begin
                    wb_reg_write <= ex_reg_write && (ex_rd != 5'd0);
                    wb_data      <= ex_result;
                    wb_exc       <= 3'd0;
                end
            end
            if (w_done_ack) begin
                bus_req      <= 1'b0;
                wb_valid     <= 1'b1;
                wb_rd        <= r_rd;
                wb_exc       <= 3'd0;
                wb_reg_write <= !bus_we && r_reg_write && (r_rd != 5'd0);
                wb_data      <= bus_we ? 32'd0 : w_load_data;
            end else if (w_done_to) begin
                bus_req      <= 1'b0;
                wb_valid     <= 1'b1;
                wb_rd        <= r_rd;
                wb_exc       <= 3'd3;
                wb_exc_addr  <= r_addr;
                wb_reg_write <= 1'b0;
                wb_data      <= 32'd0;
            end else if (r_state == StBus) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage of the RV32IM pipeline, directly downstream of the execute-stage ALU. Takes the ALU result as an effective address (or as a pass-through result), performs byte/halfword/word loads and stores over a simple request/acknowledge data bus, and delivers one registered result per instruction to writeback. It stalls execute while a bus transaction is outstanding and reports misaligned accesses and bus timeouts.

## Interface
- BUS_TIMEOUT, 255: cycles to wait for `bus_ack` after `bus_req` rises; 0 disables the timeout.
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  unit accepts an instruction this cycle.
- ex_result  in  32  ALU result: address for memory ops, data for all other ops.
- ex_store_data  in  32  rs2 value for stores.
- ex_mem_op  in  4  0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9–15 treated as NONE.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes rd.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, `{ex_result[31:2],2'b00}`.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  write data.
- bus_ack  in  1  transaction complete; `bus_rdata` is valid in the same cycle.
- bus_rdata  in  32  read data.
- wb_valid  out  1  one-cycle pulse: result available.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  write enable to the register file.
- wb_data  out  32  result.
- wb_exc  out  3  0 none, 1 load misaligned, 2 store misaligned, 3 bus timeout.
- wb_exc_addr  out  32  full faulting byte address.

## Operation
- FSM states:
  - IDLE: `ex_ready=1`.
  - BUS: `bus_req=1`, `ex_ready=0`.
- Accept condition: `ex_valid && ex_ready`.
- NONE op accepted: next cycle `wb_valid=1`, `wb_data=ex_result`, `wb_rd=ex_rd`, `wb_reg_write=ex_reg_write && ex_rd!=0`, `wb_exc=0`. State stays IDLE.
- Alignment rules: halfword ops require `addr[0]==0`; word ops require `addr[1:0]==0`.
- Misaligned access accepted: no bus request is made. Next cycle `wb_valid=1`, `wb_reg_write=0`, `wb_data=0`, `wb_exc` = 1 for loads or 2 for stores, `wb_exc_addr=ex_result`. State stays IDLE.
- Aligned memory op accepted: register the address, the op, rd and the formatted store data, then go to BUS.
- Store formatting:
  - SB: `be=4'b0001<<addr[1:0]`, `wdata={4{sd[7:0]}}`.
  - SH: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata={2{sd[15:0]}}`.
  - SW: `be=4'b1111`, `wdata=sd`.
- Loads drive `bus_we=0` and `be=4'b1111`.
- BUS state: all `bus_*` outputs are held stable until the ack or the timeout.
- On `bus_ack`: return to IDLE, and next cycle `wb_valid=1`.
- Load result: shift `bus_rdata` right by `8*addr[1:0]`, then take the byte or halfword. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store result: `wb_reg_write=0`, `wb_data=0`.
- Timeout: a counter clears on entry to BUS and increments every BUS cycle without an ack. When it reaches BUS_TIMEOUT (with BUS_TIMEOUT≠0): drop `bus_req`, go to IDLE, next cycle `wb_valid=1`, `wb_exc=3`, `wb_exc_addr` = byte address, `wb_reg_write=0`.
- An ack in the same cycle the counter reaches the limit counts as success.
- `bus_ack` while IDLE is ignored.
- Reset, including mid-transaction:
  - State goes to IDLE; the timeout counter and all outputs go to 0.
  - A late `bus_ack` after reset is ignored.
  - The bus side must tolerate a request withdrawn by reset.

## Timing
- Reset values:
  - `ex_ready=1`.
  - `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata` = 0.
  - `wb_valid`, `wb_rd`, `wb_reg_write`, `wb_data`, `wb_exc`, `wb_exc_addr` = 0.
- All outputs are registered except `ex_ready`, which is decoded from the state.
- NONE/misaligned ops: latency 1 cycle. Back-to-back acceptance allowed, giving 1 instruction/cycle.
- Memory op, accepted in cycle 0:
  - `bus_req` goes high in cycle 1.
  - An ack at cycle k (k≥1) gives `wb_valid` at k+1; IDLE and `ex_ready=1` from k+1.
  - A zero-wait-state bus gives a 2-cycle latency; the next instruction can be accepted at cycle 2.
- `bus_req` falls in the cycle after the ack.
- `wb_*` fields other than `wb_valid` hold their last value between pulses.

## Test plan
- NONE op, `ex_result=32'h1234_5678`, rd=5, reg_write=1 → next cycle `wb_valid=1`, `wb_data=32'h12345678`, `wb_reg_write=1`. A rd=0 variant gives `wb_reg_write=0`.
- LB at `addr 0x1003`, rdata `0x80FF_0000`, ack in the first BUS cycle → `bus_addr=0x1000`, `be=4'hF`, `wb_data=0xFFFF_FF80`. LBU at the same address → `0x0000_0080`. LH at `0x1002` → `0xFFFF_80FF`. `wb_valid` two cycles after acceptance.
- SH at `0x2002`, store_data `0xAAAA_BEEF`, ack delayed 3 cycles → `bus_we=1`, `be=4'b1100`, `wdata=0xBEEF_BEEF`, bus held stable 3 cycles, `ex_ready=0` throughout, then `wb_valid` with `wb_reg_write=0`.
- LW at `0x3001` → no `bus_req`, next cycle `wb_exc=1`, `wb_exc_addr=0x3001`. SW at `0x3002` → `wb_exc=2`.
- BUS_TIMEOUT=4, load with ack never given → `bus_req` high for 4 cycles, then `wb_exc=3`. Back in IDLE, a spurious ack is ignored.
- Reset asserted in the second BUS cycle → next cycle all outputs 0, `ex_ready=1`. An ack one cycle later produces no `wb_valid`.
